stream_mux: RTL and testbench
=============================

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 Parameter: bit_size, default 18, width of each data channel.
REQ-003 Parameter: num_ch, default 4, number of input channels; legal range 2..2^sel_width.
REQ-004 Parameter: sel_width, default 2, width of sel and out_ch.
REQ-005 Parameter: rr_mode, default 0; 0 = external select, 1 = round-robin arbitration (sel ignored).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_data  input  num_ch*bit_size  channel k at bits [k*bit_size +: bit_size].
REQ-009 in_valid  input  num_ch  per-channel data valid.
REQ-010 in_ready  output  num_ch  per-channel accept; at most one bit high per cycle.
REQ-011 sel  input  sel_width  channel select (rr_mode=0 only).
REQ-012 out_data  output  bit_size  registered selected data.
REQ-013 out_valid  output  1  out_data holds an unconsumed word.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 out_ch  output  sel_width  channel index the word in out_data came from.

Function
REQ-016 Transfer on channel k SHALL occur in a cycle where in_valid[k] and in_ready[k] are both high; output transfer where out_valid and out_ready are both high.
REQ-017 Output register SHALL be "open" when out_valid=0 or out_ready=1 (accept and drain in the same cycle permitted).
REQ-018 rr_mode=0: grant = sel when sel < num_ch and in_valid[sel]=1; otherwise no grant.
REQ-019 rr_mode=0, sel >= num_ch: all in_ready SHALL be 0 and no word SHALL be captured.
REQ-020 rr_mode=1: grant = first k with in_valid[k]=1 searching from (last_grant+1) mod num_ch upward, wrapping at num_ch.
REQ-021 last_grant SHALL update only on an accepted input transfer; unaccepted cycles SHALL not advance it.
REQ-022 in_ready[k] SHALL be 1 only for the granted channel and only while the output register is open; in_ready SHALL be combinational from in_valid, sel, last_grant, out_valid, out_ready.
REQ-023 On input transfer from channel k: out_data <= channel k data, out_ch <= k, out_valid <= 1 at the next edge (latency 1 cycle).
REQ-024 Output drained with no new input transfer: out_valid <= 0; out_data and out_ch SHALL hold their last values.
REQ-025 While out_valid=1 and out_ready=0: out_data, out_ch, out_valid SHALL stay stable regardless of sel, in_valid or in_data changes.
REQ-026 Sustained throughput SHALL be one word per cycle when out_ready is held high and a grant exists every cycle.
REQ-027 No word SHALL be dropped or duplicated; each input transfer produces exactly one output transfer.

Reset
REQ-028 While rst=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, last_grant=num_ch-1 (channel 0 highest priority first).
REQ-029 While rst=1, in_ready SHALL be all 0.
REQ-030 Reset asserted mid-stall SHALL discard the held word; first post-reset transfer SHALL follow REQ-028 priorities.

Verification
REQ-031 rr_mode=0, sel=2, in_valid=4'b0100, ch2 data=18'h2A5A5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=18'h2A5A5, out_ch=2.
REQ-032 rr_mode=1, in_valid=4'b1111 held, out_ready=1, after reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-033 rr_mode=1, out_ready=0 for 3 cycles after a captured word from ch1 -> out_data/out_ch stable, in_ready=0 all 3 cycles, last_grant stays 1; out_ready=1 then grants ch2.
REQ-034 rr_mode=0, num_ch=3, sel_width=2, sel=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
REQ-035 rr_mode=1, in_valid=4'b1001, after a ch3 grant -> next grant ch0 (wrap-around).
REQ-036 Reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0, in_ready=0.

Source files
------------

// File: rtl/stream_mux.sv
// stream_mux
//   N-to-1 stream multiplexer with a single registered output stage.
//   Channel choice is either an external select (rr_mode = 0) or a
//   round-robin arbiter (rr_mode = 1) that starts its search one past
//   the last channel that actually transferred.
//
// Handshake (same rule on every port pair): a word moves in any cycle where
// valid and ready are both high at the rising edge. Valid must not depend on
// ready. in_ready here is combinational from in_valid, sel, the arbiter
// history and the output register state; out_valid/out_data/out_ch are
// registered.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_data   in   num_ch*bit_size, channel k at [k*bit_size +: bit_size]
//   in_valid  in   num_ch, per-channel valid
//   in_ready  out  num_ch, per-channel accept, at most one bit high
//   sel       in   sel_width, channel select (ignored when rr_mode = 1)
//   out_data  out  bit_size, registered selected word
//   out_valid out  out_data holds an unconsumed word
//   out_ready in   downstream accepts out_data
//   out_ch    out  sel_width, source channel of out_data
module stream_mux #(
  parameter int bit_size  = 18,
  parameter int num_ch    = 4,
  parameter int sel_width = 2,
  parameter int rr_mode   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [num_ch*bit_size-1:0]   in_data,
  input  logic [num_ch-1:0]            in_valid,
  output logic [num_ch-1:0]            in_ready,
  input  logic [sel_width-1:0]         sel,
  output logic [bit_size-1:0]          out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sel_width-1:0]         out_ch
);

  // After reset the arbiter behaves as if the last channel was just served,
  // so the first search starts at channel 0.
  localparam logic [sel_width-1:0] last_init = sel_width'(num_ch - 1);

  logic [sel_width-1:0] last_grant;
  logic                 out_open;
  logic                 grant_ok;
  logic [sel_width-1:0] grant_idx;
  logic [bit_size-1:0]  grant_data;
  logic                 in_fire;

  // Output register can take a new word when empty or being drained now.
  assign out_open = !out_valid || out_ready;

  // Grant selection.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    if (rr_mode != 0) begin
      // First pass: lowest valid channel strictly above last_grant.
      for (int k = 0; k < num_ch; k++) begin
        if (!grant_ok && in_valid[k] && (k > int'(last_grant))) begin
          grant_ok  = 1'b1;
          grant_idx = k[sel_width-1:0];
        end
      end
      // Wrap-around pass: lowest valid channel at or below last_grant.
      for (int k = 0; k < num_ch; k++) begin
        if (!grant_ok && in_valid[k] && (k <= int'(last_grant))) begin
          grant_ok  = 1'b1;
          grant_idx = k[sel_width-1:0];
        end
      end
    end else begin
      // Out-of-range selects match no k and therefore grant nothing.
      for (int k = 0; k < num_ch; k++) begin
        if (int'(sel) == k) begin
          grant_ok  = in_valid[k];
          grant_idx = k[sel_width-1:0];
        end
      end
    end
  end

  // Ready is one-hot on the granted channel, gated by output space and reset.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < num_ch; k++) begin
      if (!rst && out_open && grant_ok && (grant_idx == k[sel_width-1:0])) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < num_ch; k++) begin
      if (grant_idx == k[sel_width-1:0]) begin
        grant_data = in_data[k*bit_size +: bit_size];
      end
    end
  end

  assign in_fire = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= last_init;
    end else if (in_fire) begin
      out_valid  <= 1'b1;
      out_data   <= grant_data;
      out_ch     <= grant_idx;
      last_grant <= grant_idx;
    end else if (out_valid && out_ready) begin
      // Drained with nothing new: data and channel keep their last values.
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;

  localparam int bw = 18;

  logic clk;
  logic rst;

  // Instance a: external select, 4 channels
  logic [4*bw-1:0] a_in_data;
  logic [3:0]      a_in_valid;
  logic [3:0]      a_in_ready;
  logic [1:0]      a_sel;
  logic [bw-1:0]   a_out_data;
  logic            a_out_valid;
  logic            a_out_ready;
  logic [1:0]      a_out_ch;

  // Instance b: round-robin, 4 channels
  logic [4*bw-1:0] b_in_data;
  logic [3:0]      b_in_valid;
  logic [3:0]      b_in_ready;
  logic [1:0]      b_sel;
  logic [bw-1:0]   b_out_data;
  logic            b_out_valid;
  logic            b_out_ready;
  logic [1:0]      b_out_ch;

  // Instance c: external select, 3 channels, 2-bit select
  logic [3*bw-1:0] c_in_data;
  logic [2:0]      c_in_valid;
  logic [2:0]      c_in_ready;
  logic [1:0]      c_sel;
  logic [bw-1:0]   c_out_data;
  logic            c_out_valid;
  logic            c_out_ready;
  logic [1:0]      c_out_ch;

  int checks = 0;
  int errors = 0;

  localparam logic [bw-1:0] d0 = 18'h00A01;
  localparam logic [bw-1:0] d1 = 18'h11B12;
  localparam logic [bw-1:0] d2 = 18'h2A5A5;
  localparam logic [bw-1:0] d3 = 18'h33C34;

  stream_mux #(.bit_size(bw), .num_ch(4), .sel_width(2), .rr_mode(0)) u_sel (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch)
  );

  stream_mux #(.bit_size(bw), .num_ch(4), .sel_width(2), .rr_mode(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch)
  );

  stream_mux #(.bit_size(bw), .num_ch(3), .sel_width(2), .rr_mode(0)) u_sel3 (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ch(c_out_ch)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    a_in_data   = {d3, d2, d1, d0};
    b_in_data   = {d3, d2, d1, d0};
    c_in_data   = {d2, d1, d0};
    a_in_valid  = 4'b1111;
    b_in_valid  = 4'b1111;
    c_in_valid  = 3'b111;
    a_sel       = 2'd0;
    b_sel       = 2'd0;
    c_sel       = 2'd0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    c_out_ready = 1'b1;

    // ---- reset state, ready held low during reset
    tick();
    tick();
    check("rst_a_in_ready", 32'(a_in_ready), 32'h0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'h0);
    check("rst_a_out_valid", 32'(a_out_valid), 32'h0);
    check("rst_a_out_data", 32'(a_out_data), 32'h0);
    check("rst_a_out_ch", 32'(a_out_ch), 32'h0);
    check("rst_b_last_grant", 32'(u_rr.last_grant), 32'h3);

    // ---- select mode: basic transfer from ch2
    rst        = 1'b0;
    a_sel      = 2'd2;
    a_in_valid = 4'b0100;
    b_in_valid = 4'b0000;
    c_in_valid = 3'b000;
    #1;
    check("sel_in_ready", 32'(a_in_ready), 32'h4);
    tick();
    check("sel_out_valid", 32'(a_out_valid), 32'h1);
    check("sel_out_data", 32'(a_out_data), 32'(d2));
    check("sel_out_ch", 32'(a_out_ch), 32'h2);

    // ---- drain with no new input: data/ch hold
    a_in_valid = 4'b0000;
    #1;
    check("drain_in_ready", 32'(a_in_ready), 32'h0);
    tick();
    check("drain_out_valid", 32'(a_out_valid), 32'h0);
    check("drain_out_data", 32'(a_out_data), 32'(d2));
    check("drain_out_ch", 32'(a_out_ch), 32'h2);

    // ---- selected channel not valid: no grant
    a_sel      = 2'd1;
    a_in_valid = 4'b0100;
    #1;
    check("selnv_in_ready", 32'(a_in_ready), 32'h0);
    tick();
    check("selnv_out_valid", 32'(a_out_valid), 32'h0);

    // ---- capture ch1 then stall while inputs change
    a_in_valid = 4'b0010;
    tick();
    check("cap1_out_data", 32'(a_out_data), 32'(d1));
    check("cap1_out_ch", 32'(a_out_ch), 32'h1);
    a_out_ready = 1'b0;
    a_sel       = 2'd3;
    a_in_valid  = 4'b1000;
    a_in_data   = {18'h3FFFF, d2, 18'h00000, d0};
    #1;
    check("stall_in_ready", 32'(a_in_ready), 32'h0);
    tick();
    check("stall_out_valid", 32'(a_out_valid), 32'h1);
    check("stall_out_data", 32'(a_out_data), 32'(d1));
    check("stall_out_ch", 32'(a_out_ch), 32'h1);

    // ---- reset mid-stall discards held word
    rst = 1'b1;
    tick();
    check("rstst_out_valid", 32'(a_out_valid), 32'h0);
    check("rstst_out_data", 32'(a_out_data), 32'h0);
    check("rstst_out_ch", 32'(a_out_ch), 32'h0);
    check("rstst_in_ready", 32'(a_in_ready), 32'h0);
    rst         = 1'b0;
    a_out_ready = 1'b1;
    a_in_data   = {d3, d2, d1, d0};
    a_in_valid  = 4'b0000;

    // ---- 3-channel instance: out-of-range select grants nothing
    c_sel      = 2'd3;
    c_in_valid = 3'b111;
    #1;
    check("oor_in_ready", 32'(c_in_ready), 32'h0);
    tick();
    check("oor_out_valid", 32'(c_out_valid), 32'h0);
    tick();
    check("oor_out_valid2", 32'(c_out_valid), 32'h0);
    c_sel = 2'd0;
    #1;
    check("c_sel0_in_ready", 32'(c_in_ready), 32'h1);
    tick();
    check("c_sel0_out_data", 32'(c_out_data), 32'(d0));
    c_in_valid = 3'b000;

    // ---- round-robin: all valid, sequence 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    b_in_valid = 4'b1111;
    #1;
    check("rr_first_ready", 32'(b_in_ready), 32'h1);
    tick();
    check("rr_seq0_ch", 32'(b_out_ch), 32'h0);
    check("rr_seq0_data", 32'(b_out_data), 32'(d0));
    tick();
    check("rr_seq1_ch", 32'(b_out_ch), 32'h1);
    check("rr_seq1_valid", 32'(b_out_valid), 32'h1);
    tick();
    check("rr_seq2_ch", 32'(b_out_ch), 32'h2);
    check("rr_seq2_valid", 32'(b_out_valid), 32'h1);
    tick();
    check("rr_seq3_ch", 32'(b_out_ch), 32'h3);
    check("rr_seq3_data", 32'(b_out_data), 32'(d3));
    tick();
    check("rr_seq4_ch", 32'(b_out_ch), 32'h0);
    check("rr_seq4_valid", 32'(b_out_valid), 32'h1);

    // ---- round-robin stall after a ch1 capture
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    b_in_valid = 4'b0010;
    tick();
    check("rrst_cap_ch", 32'(b_out_ch), 32'h1);
    b_out_ready = 1'b0;
    b_in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rrst_in_ready", 32'(b_in_ready), 32'h0);
      tick();
      check("rrst_out_ch", 32'(b_out_ch), 32'h1);
      check("rrst_out_data", 32'(b_out_data), 32'(d1));
      check("rrst_out_valid", 32'(b_out_valid), 32'h1);
      check("rrst_last_grant", 32'(u_rr.last_grant), 32'h1);
    end
    b_out_ready = 1'b1;
    #1;
    check("rrst_resume_ready", 32'(b_in_ready), 32'h4);
    tick();
    check("rrst_resume_ch", 32'(b_out_ch), 32'h2);

    // ---- wrap-around: ch3 then ch0
    b_in_valid = 4'b1000;
    tick();
    check("wrap_ch3", 32'(b_out_ch), 32'h3);
    b_in_valid = 4'b1001;
    #1;
    check("wrap_ready", 32'(b_in_ready), 32'h1);
    tick();
    check("wrap_ch0", 32'(b_out_ch), 32'h0);

    // ---- round-robin reset mid-stall, then priority restarts at ch0
    b_out_ready = 1'b0;
    b_in_valid  = 4'b1111;
    tick();
    rst = 1'b1;
    tick();
    check("rrrst_out_valid", 32'(b_out_valid), 32'h0);
    check("rrrst_last_grant", 32'(u_rr.last_grant), 32'h3);
    rst         = 1'b0;
    b_out_ready = 1'b1;
    b_in_valid  = 4'b1010;
    #1;
    check("rrrst_ready", 32'(b_in_ready), 32'h2);
    tick();
    check("rrrst_ch", 32'(b_out_ch), 32'h1);
    check("rrrst_data", 32'(b_out_data), 32'(d1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
